// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] v,
        input logic            neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor, so shifted < 2*divisor and the borrow bit decides
    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             hiWr,
    input  logic             loWr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t state;
    state_t state_n;

    logic [4:0]         count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] start_acc;
    logic [WIDTH-1:0]   start_mcand;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;

    // Divide: acc[63:32] is the partial remainder, acc[31:0] shifts
    // dividend bits out the top and quotient bits in at the bottom.
    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem     (acc[2*WIDTH-1:WIDTH]),
        .bit_in  (acc[WIDTH-1]),
        .divisor (mcand),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (count == LAST) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sgn_a       = ~op[0] & busA[WIDTH-1];
        sgn_b       = ~op[0] & busB[WIDTH-1];
        mag_a       = mag(busA, sgn_a);
        mag_b       = mag(busB, sgn_b);
        start_acc   = op[1] ? {{WIDTH{1'b0}}, mag_a}
                            : {{WIDTH{1'b0}}, mag_b};
        start_mcand = op[1] ? mag_b : mag_a;

        // Multiply: add multiplicand into the upper half, shift right
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_next = {rem_next, acc[WIDTH-2:0], q_bit};

        prod_s = neg_q ? -acc : acc;
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            if (dz) begin
                res_hi = a_raw;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = mag(acc[2*WIDTH-1:WIDTH], neg_r);
                res_lo = mag(acc[WIDTH-1:0], neg_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= start_acc;
                        mcand  <= start_mcand;
                        a_raw  <= busA;
                        is_div <= op[1];
                        neg_q  <= sgn_a ^ sgn_b;
                        neg_r  <= sgn_a;
                        dz     <= (busB == '0);
                        count  <= '0;
                        busy   <= 1'b1;
                    end else begin
                        if (hiWr) hi <= busA;
                        if (loWr) lo <= busA;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 5'd1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
